debug_readout_ctrl: RTL and testbench
=====================================

# debug_readout_ctrl

Sequencer for the MIPS debug database. While the pipeline runs it keeps the database in capture mode. On a dump request it freezes the database and selects each stored word in turn. It then streams the 16 resulting bytes, MSB first, to the UART transmitter over a start/done handshake. It sits between the top-level debug unit and the database/UART pair.

## Interface
Parameters:
- LONGITUD_INSTRUCCION, 32, width of database data word
- CANT_BITS_CONTROL, 3, width of database control code
- UART_DATA_BITS, 8, width of one transmitted byte

Ports:
- i_clock  in  1  system clock, rising edge
- i_soft_reset  in  1  reset, asynchronous, active-low
- i_start  in  1  dump request, level-sampled, acted on only in IDLE
- i_clear  in  1  database clear request, acted on only in IDLE
- i_dato  in  LONGITUD_INSTRUCCION  selected word from database
- i_tx_done  in  1  UART byte-complete pulse
- o_control  out  CANT_BITS_CONTROL  control code to database
- o_tx_start  out  1  one-cycle UART start pulse
- o_tx_data  out  UART_DATA_BITS  byte to transmit, valid while o_tx_start=1
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when the last byte completes

## Operation
- Control codes:
  - CTRL_CLEAR=0
  - CTRL_CAPTURE=1
  - CTRL_SEL_PC=2
  - CTRL_SEL_PC4=4
  - CTRL_SEL_INSTR=5
  - CTRL_SEL_CICLOS=6
- Code 3 is never driven.
- Dump order: PC, PC+4, instruction, cycle counter. Each word is 4 bytes, MSB first, so a dump is 16 bytes.
- States:
  - IDLE
    - o_control=CAPTURE.
    - i_start → SELECT, with word index 0. i_start has priority over i_clear.
    - i_clear (without i_start) → CLEAR.
  - CLEAR
    - o_control=CLEAR for exactly one cycle, then → IDLE.
  - SELECT
    - o_control=code[word index], one cycle, then → LATCH.
  - LATCH
    - o_control holds the same code.
    - i_dato is now valid and is loaded into a 32-bit shift register.
    - Byte count is set to 0. Pulse o_tx_start with i_dato[31:24], then → WAIT_TX.
  - WAIT_TX
    - o_control holds the select code.
    - i_tx_done is ignored in the cycle o_tx_start is high.
    - On i_tx_done with byte count <3: shift left 8, increment byte count, pulse o_tx_start with the new top byte, stay in WAIT_TX.
    - On i_tx_done with byte count =3 and word index <3: increment word index, → SELECT.
    - On i_tx_done with byte count =3 and word index =3: → DONE.
  - DONE
    - o_done=1 for one cycle, o_control holds CTRL_SEL_CICLOS, then → IDLE.
- Requests while busy:
  - i_start and i_clear are ignored outside IDLE.
  - A level still high on return to IDLE starts a new action.
- Counters:
  - Word index is 2 bits and byte count is 2 bits.
  - Neither wraps mid-dump; both terminate at 3.

## Timing
- Reset values:
  - o_control=CAPTURE (1)
  - o_tx_start=0
  - o_tx_data=0
  - o_busy=0
  - o_done=0
  - state=IDLE, word index=0, byte count=0, shift register=0
- Reset takes effect immediately at any point, including mid-dump. There is no partial byte continuation after release.
- All outputs are registered.
- i_start is sampled at edge E0, then:
  - o_control=SEL_PC is visible after E0.
  - The database updates i_dato at E1.
  - The controller latches at E2.
  - o_tx_start is high during the cycle after E2, which is 3 cycles after the request edge.
- After i_tx_done (not the last byte of a word), the next o_tx_start is high during the next cycle.
- After the last byte of a word, there are 3 cycles from the i_tx_done edge to the next o_tx_start: SELECT, LATCH, then the start pulse.
- o_done is high during the cycle after the final i_tx_done is sampled.
- o_busy then falls one cycle later.

## Structure
- Shared package debug_pkg holds:
  - the CTRL_* code constants, which the database uses too
  - the state enumeration
  - NUM_DUMP_WORDS=4
  - BYTES_PER_WORD=4
- The state machine, counters and shift register live in one module; no sub-module is needed.

## Test plan
- Full dump:
  - Setup: database model holds pc=0x010, pc4=0x014, instr=0x8C220004, ciclos=0x025. The UART model returns i_tx_done 5 cycles after each start.
  - Required: bytes 00 00 00 10 00 00 00 14 8C 22 00 04 00 00 00 25 in order, exactly 16 o_tx_start pulses, one o_done pulse.
- Control sequence check: o_control reads 1→2→4→5→6→1 across the dump, and code 3 and code 0 never appear.
- Clear: i_clear pulsed in IDLE → o_control=0 for exactly one cycle, then 1. i_clear raised together with i_start → the dump starts and no clear occurs.
- Busy lockout: i_start and i_clear toggled during WAIT_TX → no effect. The byte stream is unchanged.
- Reset mid-dump: i_soft_reset driven low in WAIT_TX of byte 6 → all outputs take their reset values asynchronously, before the next clock edge. A new i_start afterwards → the dump restarts from byte 00 of pc.
- Spurious done: i_tx_done asserted in the same cycle as o_tx_start → ignored, and the byte count does not advance.

Source files
------------

// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared control codes, states and dump geometry for the MIPS debug database
package debug_pkg;

    localparam logic [2:0] CTRL_CLEAR      = 3'd0;
    localparam logic [2:0] CTRL_CAPTURE    = 3'd1;
    localparam logic [2:0] CTRL_SEL_PC     = 3'd2;
    localparam logic [2:0] CTRL_SEL_PC4    = 3'd4;
    localparam logic [2:0] CTRL_SEL_INSTR  = 3'd5;
    localparam logic [2:0] CTRL_SEL_CICLOS = 3'd6;

    localparam int NUM_DUMP_WORDS = 4;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SELECT,
        ST_LATCH,
        ST_WAIT_TX,
        ST_DONE
    } state_t;

    // Dump order: PC, PC+4, instruction, cycle counter
    function automatic logic [2:0] word_ctrl(input logic [1:0] idx);
        case (idx)
            2'd0:    return CTRL_SEL_PC;
            2'd1:    return CTRL_SEL_PC4;
            2'd2:    return CTRL_SEL_INSTR;
            default: return CTRL_SEL_CICLOS;
        endcase
    endfunction

endpackage

// File: rtl/debug_readout_ctrl.sv
// rtl/debug_readout_ctrl.sv - freezes the debug database and streams its words MSB-first to the UART
module debug_readout_ctrl
    import debug_pkg::*;
#(
    parameter int LONGITUD_INSTRUCCION = 32,
    parameter int CANT_BITS_CONTROL    = 3,
    parameter int UART_DATA_BITS       = 8
) (
    input  logic                            i_clock,
    input  logic                            i_soft_reset,
    input  logic                            i_start,
    input  logic                            i_clear,
    input  logic [LONGITUD_INSTRUCCION-1:0] i_dato,
    input  logic                            i_tx_done,
    output logic [CANT_BITS_CONTROL-1:0]    o_control,
    output logic                            o_tx_start,
    output logic [UART_DATA_BITS-1:0]       o_tx_data,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam logic [1:0] LAST_WORD = 2'(NUM_DUMP_WORDS - 1);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    state_t                          state, state_nxt;
    logic [1:0]                      word_idx, word_idx_nxt;
    logic [1:0]                      byte_cnt, byte_cnt_nxt;
    logic [LONGITUD_INSTRUCCION-1:0] shift_reg, shift_nxt, shifted;
    logic [CANT_BITS_CONTROL-1:0]    control_nxt;
    logic                            tx_start_nxt, busy_nxt, done_nxt;
    logic [UART_DATA_BITS-1:0]       tx_data_nxt;

    assign shifted = shift_reg << UART_DATA_BITS;

    always_ff @(posedge i_clock or negedge i_soft_reset) begin
        if (!i_soft_reset) begin
            state      <= ST_IDLE;
            word_idx   <= 2'd0;
            byte_cnt   <= 2'd0;
            shift_reg  <= '0;
            o_control  <= CANT_BITS_CONTROL'(CTRL_CAPTURE);
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state      <= state_nxt;
            word_idx   <= word_idx_nxt;
            byte_cnt   <= byte_cnt_nxt;
            shift_reg  <= shift_nxt;
            o_control  <= control_nxt;
            o_tx_start <= tx_start_nxt;
            o_tx_data  <= tx_data_nxt;
            o_busy     <= busy_nxt;
            o_done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        word_idx_nxt = word_idx;
        byte_cnt_nxt = byte_cnt;
        shift_nxt    = shift_reg;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = o_tx_data;
        done_nxt     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt    = ST_SELECT;
                    word_idx_nxt = 2'd0;
                end else if (i_clear) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR:  state_nxt = ST_IDLE;
            ST_SELECT: state_nxt = ST_LATCH;
            ST_LATCH: begin
                shift_nxt    = i_dato;
                byte_cnt_nxt = 2'd0;
                tx_start_nxt = 1'b1;
                tx_data_nxt  = i_dato[LONGITUD_INSTRUCCION-1 -: UART_DATA_BITS];
                state_nxt    = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                // A done coinciding with our own start pulse belongs to the previous byte
                if (i_tx_done && !o_tx_start) begin
                    if (byte_cnt != LAST_BYTE) begin
                        shift_nxt    = shifted;
                        byte_cnt_nxt = byte_cnt + 2'd1;
                        tx_start_nxt = 1'b1;
                        tx_data_nxt  = shifted[LONGITUD_INSTRUCCION-1 -: UART_DATA_BITS];
                    end else if (word_idx != LAST_WORD) begin
                        word_idx_nxt = word_idx + 2'd1;
                        state_nxt    = ST_SELECT;
                    end else begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase

        // Outputs are registered, so the control code is derived from the state being entered
        case (state_nxt)
            ST_IDLE:  control_nxt = CANT_BITS_CONTROL'(CTRL_CAPTURE);
            ST_CLEAR: control_nxt = CANT_BITS_CONTROL'(CTRL_CLEAR);
            default:  control_nxt = CANT_BITS_CONTROL'(word_ctrl(word_idx_nxt));
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

endmodule

// File: tb/tb_debug_readout_ctrl.sv
// tb/tb_debug_readout_ctrl.sv - directed self-checking bench for debug_readout_ctrl
module tb_debug_readout_ctrl;
    import debug_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] dato = 32'h0;
    logic        uart_done = 1'b0;
    logic        spur_done = 1'b0;
    logic        uart_en = 1'b1;
    logic        tx_done;
    logic [2:0]  control;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        done;

    logic [31:0] db_pc = 32'h0000_0010;
    logic [31:0] db_pc4 = 32'h0000_0014;
    logic [31:0] db_instr = 32'h8C22_0004;
    logic [31:0] db_ciclos = 32'h0000_0025;

    int          errors = 0;
    int          checks = 0;
    int          cycle = 0;
    int          done_cnt = 0;
    int          saw_bad = 0;
    int          ucnt = 0;
    logic [7:0]  bytes_q[$];
    int          start_cyc[$];
    logic [2:0]  ctrl_trace[$];
    logic [7:0]  exp_bytes[16] = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h14,
                                   8'h8C, 8'h22, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h25};
    logic [2:0]  exp_trace[6] = '{3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd1};

    assign tx_done = uart_done | spur_done;

    debug_readout_ctrl dut (
        .i_clock      (clk),
        .i_soft_reset (rst_n),
        .i_start      (start),
        .i_clear      (clear),
        .i_dato       (dato),
        .i_tx_done    (tx_done),
        .o_control    (control),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .o_busy       (busy),
        .o_done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    always @(posedge clk) begin
        case (control)
            CTRL_SEL_PC:     dato <= db_pc;
            CTRL_SEL_PC4:    dato <= db_pc4;
            CTRL_SEL_INSTR:  dato <= db_instr;
            CTRL_SEL_CICLOS: dato <= db_ciclos;
            default:         dato <= dato;
        endcase
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            ucnt      <= 0;
            uart_done <= 1'b0;
        end else begin
            uart_done <= 1'b0;
            if (tx_start && uart_en) begin
                ucnt <= 5;
            end else if (ucnt != 0) begin
                ucnt <= ucnt - 1;
                if (ucnt == 1) uart_done <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (tx_start) begin
            bytes_q.push_back(tx_data);
            start_cyc.push_back(cycle);
        end
        if (done) done_cnt++;
        if (ctrl_trace.size() == 0 || ctrl_trace[ctrl_trace.size()-1] != control)
            ctrl_trace.push_back(control);
        if (control == 3'd0 || control == 3'd3) saw_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_rec();
        bytes_q.delete();
        start_cyc.delete();
        ctrl_trace.delete();
        ctrl_trace.push_back(control);
        done_cnt = 0;
        saw_bad  = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_cnt == 0 && n < 400) begin
            tick();
            n++;
        end
        chk("dump_done_within_budget", 32'(n < 400), 32'd1);
    endtask

    task automatic wait_bytes(input int nb);
        int n = 0;
        while (bytes_q.size() < nb && n < 400) begin
            tick();
            n++;
        end
        chk("byte_reached_within_budget", 32'(n < 400), 32'd1);
    endtask

    task automatic check_stream(input string tag);
        chk({tag, "_byte_count"}, 32'(bytes_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < bytes_q.size())
                chk($sformatf("%s_byte%0d", tag, i), 32'(bytes_q[i]), 32'(exp_bytes[i]));
            else
                chk($sformatf("%s_byte%0d_missing", tag, i), 32'd0, 32'd1);
        end
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_control", 32'(control), 32'd1);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();

        // Full dump with latency and control-sequence checks
        clear_rec();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sel_pc_after_request", 32'(control), 32'd2);
        chk("busy_after_request", 32'(busy), 32'd1);
        tick();
        chk("no_start_at_e1", 32'(tx_start), 32'd0);
        tick();
        chk("first_start_latency", 32'(tx_start), 32'd1);
        chk("first_byte", 32'(tx_data), 32'd0);
        wait_done();
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_during_done", 32'(busy), 32'd1);
        chk("ctrl_during_done", 32'(control), 32'd6);
        tick();
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_falls", 32'(busy), 32'd0);
        chk("ctrl_back_capture", 32'(control), 32'd1);
        check_stream("full");
        chk("start_count", 32'(start_cyc.size()), 32'd16);
        if (start_cyc.size() >= 5) begin
            chk("gap_within_word", 32'(start_cyc[1] - start_cyc[0]), 32'd7);
            chk("gap_across_word", 32'(start_cyc[4] - start_cyc[3]), 32'd9);
        end else begin
            chk("gap_starts_missing", 32'd0, 32'd1);
        end
        chk("trace_len", 32'(ctrl_trace.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < ctrl_trace.size())
                chk($sformatf("trace%0d", i), 32'(ctrl_trace[i]), 32'(exp_trace[i]));
        chk("no_code_0_or_3", 32'(saw_bad), 32'd0);

        // Clear in IDLE: exactly one cycle of code 0
        clear_rec();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_code", 32'(control), 32'd0);
        chk("clear_busy", 32'(busy), 32'd1);
        tick();
        chk("clear_back_capture", 32'(control), 32'd1);
        chk("clear_busy_low", 32'(busy), 32'd0);

        // Start wins over clear
        clear_rec();
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        chk("start_priority", 32'(control), 32'd2);
        wait_done();
        tick();
        chk("prio_no_clear", 32'(saw_bad), 32'd0);
        check_stream("prio");

        // Requests toggled while busy are ignored
        clear_rec();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_bytes(5);
        for (int i = 0; i < 12; i++) begin
            start = 1'(i % 2);
            clear = 1'((i + 1) % 2);
            tick();
        end
        start = 1'b0;
        clear = 1'b0;
        wait_done();
        tick();
        chk("lockout_no_clear", 32'(saw_bad), 32'd0);
        check_stream("lockout");
        tick();
        chk("lockout_idle", 32'(busy), 32'd0);

        // Asynchronous reset mid-dump, then a clean restart
        clear_rec();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_bytes(6);
        chk("mid_busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_control", 32'(control), 32'd1);
        chk("async_rst_tx_start", 32'(tx_start), 32'd0);
        chk("async_rst_tx_data", 32'(tx_data), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_rec();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        tick();
        check_stream("restart");

        // Done coinciding with the start pulse must not advance the byte count
        uart_en = 1'b0;
        db_pc = 32'h1122_3344;
        tick();
        clear_rec();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("spur_first_start", 32'(tx_start), 32'd1);
        chk("spur_first_byte", 32'(tx_data), 32'h11);
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        chk("spur_ignored", 32'(tx_start), 32'd0);
        chk("spur_data_held", 32'(tx_data), 32'h11);
        tick();
        tick();
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        chk("real_done_start", 32'(tx_start), 32'd1);
        chk("real_done_second_byte", 32'(tx_data), 32'h22);
        chk("spur_byte_count", 32'(bytes_q.size()), 32'd2);
        rst_n = 1'b0;
        tick();
        chk("final_reset_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
